csa_seq_adder: RTL

Multi-cycle carry-select adder that produces the sum consumed by the result path. It accepts W-bit operands over a valid/ready handshake and resolves one B-bit block per cycle. For each block it precomputes both candidate sums (carry-in 0 and carry-in 1), then selects the right one with the registered block carry through an `nMux` instance. The finished W-bit sum and carry-out are held behind an output valid/ready handshake.

---
 rtl/csa_pkg.sv | 10 +
 rtl/csa_seq_adder_nmux.sv | 13 +
 rtl/csa_seq_adder.sv | 101 ++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared state encoding for the sequential carry-select adder
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_seq_adder_nmux.sv
// rtl/csa_seq_adder_nmux.sv - N-bit two-way select used to pick a block candidate sum
module nMux #(
  parameter int N = 9
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         select,
  output logic [N-1:0] y
);

  assign y = select ? in1 : in0;

endmodule

// File: rtl/csa_seq_adder.sv
// rtl/csa_seq_adder.sv - multi-cycle carry-select adder, one B-bit block per cycle
module csa_seq_adder
  import csa_pkg::*;
#(
  parameter int W = 32,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int NB = W / B;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx;

  int            lo;
  logic [B-1:0]  a_blk;
  logic [B-1:0]  b_blk;
  logic [B:0]    s0;
  logic [B:0]    s1;
  logic [B:0]    sel;
  logic          last;

  assign lo    = B * int'(idx);
  assign a_blk = a_q[lo +: B];
  assign b_blk = b_q[lo +: B];

  // Both candidates are formed unconditionally; the block carry only steers the mux.
  assign s0 = {1'b0, a_blk} + {1'b0, b_blk};
  assign s1 = {1'b0, a_blk} + {1'b0, b_blk} + {{B{1'b0}}, 1'b1};

  nMux #(.N(B + 1)) u_mux (
    .in0   (s0),
    .in1   (s1),
    .select(carry_q),
    .y     (sel)
  );

  assign last = (idx == IW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[lo +: B] <= sel[B-1:0];
          carry_q      <= sel[B];
          if (last) begin
            cout  <= sel[B];
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
